// File: rtl/vtg_pkg.sv
// Shared definitions for the video timing generator.
//   - region_e    : per-axis raster region encoding
//   - SVGA_*      : default 800x600@60 timing (40 MHz pixel clock)
//   - axis_total  : helper to sum the four region lengths of one axis
package vtg_pkg;

    typedef enum logic [1:0] {
        REG_ACTIVE = 2'd0,
        REG_FP     = 2'd1,
        REG_SYNC   = 2'd2,
        REG_BP     = 2'd3
    } region_e;

    localparam int unsigned SVGA_H_ACT  = 800;
    localparam int unsigned SVGA_H_FP   = 40;
    localparam int unsigned SVGA_H_SYNC = 128;
    localparam int unsigned SVGA_H_BP   = 88;
    localparam int unsigned SVGA_V_ACT  = 600;
    localparam int unsigned SVGA_V_FP   = 1;
    localparam int unsigned SVGA_V_SYNC = 4;
    localparam int unsigned SVGA_V_BP   = 23;

    function automatic int unsigned axis_total(input int unsigned act, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

    localparam int unsigned SVGA_H_TOTAL =
        axis_total(SVGA_H_ACT, SVGA_H_FP, SVGA_H_SYNC, SVGA_H_BP);
    localparam int unsigned SVGA_V_TOTAL =
        axis_total(SVGA_V_ACT, SVGA_V_FP, SVGA_V_SYNC, SVGA_V_BP);

endpackage

// File: rtl/vtg_axis_counter.sv
// One raster axis: position counter with wrap plus the region state machine
// ACTIVE -> FP -> SYNC -> BP -> ACTIVE. Zero-length regions are skipped.
// Ports:
//   clk, rstb : clock, async active-low reset
//   adv       : advance one position (pixel tick, or end-of-line for the vertical axis)
//   clr       : synchronous return to position 0 / first region (priority over adv)
//   cnt       : current position, 0..TOTAL-1
//   region    : current region (vtg_pkg::region_e encoding)
//   last      : cnt is at TOTAL-1 (next advance wraps)
module vtg_axis_counter
    import vtg_pkg::*;
#(
    parameter int unsigned ACT   = 800,
    parameter int unsigned FP    = 40,
    parameter int unsigned SYNC  = 128,
    parameter int unsigned BP    = 88,
    parameter int unsigned CNT_W = 11
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             adv,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic [1:0]       region,
    output logic             last
);

    localparam int unsigned TOTAL = axis_total(ACT, FP, SYNC, BP);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOTAL - 1);

    function automatic int unsigned region_len(input region_e r);
        unique case (r)
            REG_ACTIVE: return ACT;
            REG_FP:     return FP;
            REG_SYNC:   return SYNC;
            REG_BP:     return BP;
        endcase
    endfunction

    function automatic region_e succ(input region_e r);
        unique case (r)
            REG_ACTIVE: return REG_FP;
            REG_FP:     return REG_SYNC;
            REG_SYNC:   return REG_BP;
            REG_BP:     return REG_ACTIVE;
        endcase
    endfunction

    // Next region with non-zero length; SYNC is never empty so this terminates.
    function automatic region_e next_region(input region_e r);
        region_e n = succ(r);
        for (int i = 0; i < 3; i++) begin
            if (region_len(n) == 0) n = succ(n);
        end
        return n;
    endfunction

    // Position at which each region ends.
    function automatic int unsigned region_end(input region_e r);
        unique case (r)
            REG_ACTIVE: return ACT - 1;
            REG_FP:     return ACT + FP - 1;
            REG_SYNC:   return ACT + FP + SYNC - 1;
            REG_BP:     return TOTAL - 1;
        endcase
    endfunction

    // Region entered at position 0 (ACTIVE whenever ACT > 0).
    localparam region_e START_REGION = (ACT > 0) ? REG_ACTIVE :
                                       (FP > 0)  ? REG_FP : REG_SYNC;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    region_e          region_q, region_d;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt_q    <= '0;
            region_q <= START_REGION;
        end else begin
            cnt_q    <= cnt_d;
            region_q <= region_d;
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        region_d = region_q;
        if (clr) begin
            cnt_d    = '0;
            region_d = START_REGION;
        end else if (adv) begin
            cnt_d = last ? '0 : cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(region_end(region_q))) begin
                region_d = next_region(region_q);
            end
        end
    end

    assign cnt    = cnt_q;
    assign region = region_q;
    assign last   = (cnt_q == LAST_CNT);

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator for the overlay/pattern layers. Produces a pixel tick,
// active-area coordinates, data enable, syncs and line/frame start markers.
// Ports:
//   clk, rstb   : clock, async active-low reset
//   run         : 1 = scan, 0 = hold idle at the frame origin
//   h_c_en      : pixel tick, one clk wide (always 1 while running when PIX_DIV=1)
//   h_c, v_c    : active-area coordinates (0 outside the active area)
//   de          : pixel is inside the active area
//   hsync/vsync : syncs, active level HS_POL/VS_POL
//   line_start  : first pixel of every line
//   frame_start : first pixel of every frame
// Build option: define VTG_ALIGN_DLY_EN to delay de, hsync, vsync, line_start and
// frame_start by one extra clk (h_c_en, h_c, v_c are not delayed).
module video_timing_gen
    import vtg_pkg::*;
#(
    parameter int unsigned H_ACT   = SVGA_H_ACT,
    parameter int unsigned H_FP    = SVGA_H_FP,
    parameter int unsigned H_SYNC  = SVGA_H_SYNC,
    parameter int unsigned H_BP    = SVGA_H_BP,
    parameter int unsigned V_ACT   = SVGA_V_ACT,
    parameter int unsigned V_FP    = SVGA_V_FP,
    parameter int unsigned V_SYNC  = SVGA_V_SYNC,
    parameter int unsigned V_BP    = SVGA_V_BP,
    parameter logic        HS_POL  = 1'b1,
    parameter logic        VS_POL  = 1'b1,
    parameter int unsigned PIX_DIV = 1
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       run,
    output logic       h_c_en,
    output logic [9:0] h_c,
    output logic [9:0] v_c,
    output logic       de,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start
);

    localparam logic [3:0] DIV_LAST = 4'(PIX_DIV - 1);

    logic [3:0]  div_q, div_d;
    logic        tick;
    logic [10:0] hcnt;
    logic [9:0]  vcnt;
    logic [1:0]  h_region, v_region;
    logic        h_last;
    logic        unused_v_last;

    assign tick = run && (div_q == DIV_LAST);

    vtg_axis_counter #(
        .ACT   (H_ACT),
        .FP    (H_FP),
        .SYNC  (H_SYNC),
        .BP    (H_BP),
        .CNT_W (11)
    ) u_h_axis (
        .clk    (clk),
        .rstb   (rstb),
        .adv    (tick),
        .clr    (!run),
        .cnt    (hcnt),
        .region (h_region),
        .last   (h_last)
    );

    vtg_axis_counter #(
        .ACT   (V_ACT),
        .FP    (V_FP),
        .SYNC  (V_SYNC),
        .BP    (V_BP),
        .CNT_W (10)
    ) u_v_axis (
        .clk    (clk),
        .rstb   (rstb),
        .adv    (tick && h_last),
        .clr    (!run),
        .cnt    (vcnt),
        .region (v_region),
        .last   (unused_v_last)
    );

    // Registered decode of the pixel at the current counter position.
    logic       h_c_en_q, h_c_en_d;
    logic [9:0] h_c_q, h_c_d;
    logic [9:0] v_c_q, v_c_d;
    logic       de_q, de_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            div_q         <= '0;
            h_c_en_q      <= 1'b0;
            h_c_q         <= '0;
            v_c_q         <= '0;
            de_q          <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_c_en_q      <= h_c_en_d;
            h_c_q         <= h_c_d;
            v_c_q         <= v_c_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_comb begin
        div_d         = div_q;
        h_c_en_d      = tick;
        h_c_d         = h_c_q;
        v_c_d         = v_c_q;
        de_d          = de_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        line_start_d  = line_start_q;
        frame_start_d = frame_start_q;
        if (!run) begin
            div_d         = '0;
            h_c_d         = '0;
            v_c_d         = '0;
            de_d          = 1'b0;
            hsync_d       = ~HS_POL;
            vsync_d       = ~VS_POL;
            line_start_d  = 1'b0;
            frame_start_d = 1'b0;
        end else begin
            div_d = tick ? '0 : div_q + 4'd1;
            // Outputs only change on a tick so they hold for the whole pixel period.
            if (tick) begin
                h_c_d         = (h_region == REG_ACTIVE) ? hcnt[9:0] : '0;
                v_c_d         = (v_region == REG_ACTIVE) ? vcnt : '0;
                de_d          = (h_region == REG_ACTIVE) && (v_region == REG_ACTIVE);
                hsync_d       = (h_region == REG_SYNC) ? HS_POL : ~HS_POL;
                vsync_d       = (v_region == REG_SYNC) ? VS_POL : ~VS_POL;
                line_start_d  = (hcnt == '0);
                frame_start_d = (hcnt == '0) && (vcnt == '0);
            end
        end
    end

    assign h_c_en = h_c_en_q;
    assign h_c    = h_c_q;
    assign v_c    = v_c_q;

`ifdef VTG_ALIGN_DLY_EN
    // Extra stage so the markers line up with the downstream layer's registered data.
    logic de_dly_q, hsync_dly_q, vsync_dly_q, line_start_dly_q, frame_start_dly_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            de_dly_q          <= 1'b0;
            hsync_dly_q       <= ~HS_POL;
            vsync_dly_q       <= ~VS_POL;
            line_start_dly_q  <= 1'b0;
            frame_start_dly_q <= 1'b0;
        end else begin
            de_dly_q          <= de_q;
            hsync_dly_q       <= hsync_q;
            vsync_dly_q       <= vsync_q;
            line_start_dly_q  <= line_start_q;
            frame_start_dly_q <= frame_start_q;
        end
    end

    assign de          = de_dly_q;
    assign hsync       = hsync_dly_q;
    assign vsync       = vsync_dly_q;
    assign line_start  = line_start_dly_q;
    assign frame_start = frame_start_dly_q;
`else
    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: two instances (PIX_DIV=1 active-high syncs,
// PIX_DIV=3 active-low syncs) with small timings H 8/2/3/2, V 4/1/2/1.
module tb_video_timing_gen;

    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
`ifdef VTG_ALIGN_DLY_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstb = 1'b1;
    logic run = 1'b0;

    logic       d1_en, d1_de, d1_hs, d1_vs, d1_ls, d1_fs;
    logic [9:0] d1_hc, d1_vc;
    logic       d3_en, d3_de, d3_hs, d3_vs, d3_ls, d3_fs;
    logic [9:0] d3_hc, d3_vc;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .PIX_DIV(1)
    ) u_dut1 (
        .clk(clk), .rstb(rstb), .run(run), .h_c_en(d1_en), .h_c(d1_hc), .v_c(d1_vc),
        .de(d1_de), .hsync(d1_hs), .vsync(d1_vs), .line_start(d1_ls), .frame_start(d1_fs)
    );

    video_timing_gen #(
        .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIX_DIV(3)
    ) u_dut3 (
        .clk(clk), .rstb(rstb), .run(run), .h_c_en(d3_en), .h_c(d3_hc), .v_c(d3_vc),
        .de(d3_de), .hsync(d3_hs), .vsync(d3_vs), .line_start(d3_ls), .frame_start(d3_fs)
    );

    typedef struct {
        bit en;
        int hc;
        int vc;
        bit de;
        bit hs;
        bit vs;
        bit ls;
        bit fs;
    } exp_t;

    typedef struct {
        int cyc;
        int hc;
        int vc;
        bit de;
        bit hs;
        bit vs;
        bit ls;
        bit fs;
    } vec_t;

    int   tests = 0;
    int   fails = 0;
    int   k = 0;           // consecutive clk edges with run=1 since the last idle/reset
    exp_t cur[2];
    exp_t prev[2];
    int   divs[2] = '{1, 3};
    bit   hpol[2] = '{1'b1, 1'b0};
    bit   vpol[2] = '{1'b1, 1'b0};

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            if (fails <= 30) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp,
                                      $time);
        end
    endtask

    // Outputs after k running edges, straight from the raster definition.
    function automatic exp_t model(input int kk, input int d, input bit hp, input bit vp);
        exp_t e;
        e.en = 1'b0; e.hc = 0; e.vc = 0; e.de = 1'b0;
        e.hs = ~hp;  e.vs = ~vp; e.ls = 1'b0; e.fs = 1'b0;
        if (kk >= d) begin
            int m;
            int f;
            int x;
            int y;
            m = kk / d - 1;
            f = m % (HT * VT);
            x = f % HT;
            y = f / HT;
            e.en = (kk % d == 0);
            e.hc = (x < HA) ? x : 0;
            e.vc = (y < VA) ? y : 0;
            e.de = (x < HA) && (y < VA);
            e.hs = (x >= HA + HF && x < HA + HF + HS) ? hp : ~hp;
            e.vs = (y >= VA + VF && y < VA + VF + VS) ? vp : ~vp;
            e.ls = (x == 0);
            e.fs = (x == 0) && (y == 0);
        end
        return e;
    endfunction

    task automatic check_dut(input int i);
        exp_t  a;
        exp_t  e;
        string t;
        if (i == 0) begin
            t = "d1";
            a.en = d1_en; a.hc = int'(d1_hc); a.vc = int'(d1_vc); a.de = d1_de;
            a.hs = d1_hs; a.vs = d1_vs; a.ls = d1_ls; a.fs = d1_fs;
        end else begin
            t = "d3";
            a.en = d3_en; a.hc = int'(d3_hc); a.vc = int'(d3_vc); a.de = d3_de;
            a.hs = d3_hs; a.vs = d3_vs; a.ls = d3_ls; a.fs = d3_fs;
        end
        e = cur[i];
        if (ALIGN) begin
            e.de = prev[i].de; e.hs = prev[i].hs; e.vs = prev[i].vs;
            e.ls = prev[i].ls; e.fs = prev[i].fs;
        end
        chk({t, ".h_c_en"}, int'(a.en), int'(e.en));
        chk({t, ".h_c"}, a.hc, e.hc);
        chk({t, ".v_c"}, a.vc, e.vc);
        chk({t, ".de"}, int'(a.de), int'(e.de));
        chk({t, ".hsync"}, int'(a.hs), int'(e.hs));
        chk({t, ".vsync"}, int'(a.vs), int'(e.vs));
        chk({t, ".line_start"}, int'(a.ls), int'(e.ls));
        chk({t, ".frame_start"}, int'(a.fs), int'(e.fs));
    endtask

    task automatic model_reset();
        k = 0;
        for (int i = 0; i < 2; i++) begin
            cur[i]  = model(0, divs[i], hpol[i], vpol[i]);
            prev[i] = cur[i];
        end
    endtask

    // One clk: update the model at the edge, compare both DUTs on the falling edge.
    task automatic step();
        @(posedge clk);
        if (!rstb) k = 0;
        else if (run) k++;
        else k = 0;
        for (int i = 0; i < 2; i++) begin
            prev[i] = cur[i];
            cur[i]  = model(k, divs[i], hpol[i], vpol[i]);
        end
        if (!rstb) model_reset();
        @(negedge clk);
        check_dut(0);
        check_dut(1);
    endtask

    task automatic go_idle();
        run = 1'b0;
        step();
        step();
    endtask

    vec_t vecs[12];

    initial begin
        // Expected dut1 outputs after N running clks (pixel N-1).
        vecs[0]  = '{1,   0, 0, 1, 0, 0, 1, 1};
        vecs[1]  = '{8,   7, 0, 1, 0, 0, 0, 0};
        vecs[2]  = '{9,   0, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{11,  0, 0, 0, 1, 0, 0, 0};
        vecs[4]  = '{13,  0, 0, 0, 1, 0, 0, 0};
        vecs[5]  = '{14,  0, 0, 0, 0, 0, 0, 0};
        vecs[6]  = '{16,  0, 1, 1, 0, 0, 1, 0};
        vecs[7]  = '{48,  2, 3, 1, 0, 0, 0, 0};
        vecs[8]  = '{61,  0, 0, 0, 0, 0, 1, 0};
        vecs[9]  = '{76,  0, 0, 0, 0, 1, 1, 0};
        vecs[10] = '{106, 0, 0, 0, 0, 0, 1, 0};
        vecs[11] = '{121, 0, 0, 1, 0, 0, 1, 1};

        model_reset();
        #2 rstb = 1'b0;
        #2;
        chk("rst.d1.h_c_en", int'(d1_en), 0);
        chk("rst.d1.de", int'(d1_de), 0);
        chk("rst.d1.hsync", int'(d1_hs), 0);
        chk("rst.d1.vsync", int'(d1_vs), 0);
        chk("rst.d3.hsync", int'(d3_hs), 1);
        chk("rst.d3.vsync", int'(d3_vs), 1);
        chk("rst.d1.frame_start", int'(d1_fs), 0);
        @(negedge clk);
        rstb = 1'b1;
        step();

        // Table vectors.
        foreach (vecs[n]) begin
            go_idle();
            run = 1'b1;
            for (int c = 0; c < vecs[n].cyc; c++) step();
            chk($sformatf("vec%0d.h_c", n), int'(d1_hc), vecs[n].hc);
            chk($sformatf("vec%0d.v_c", n), int'(d1_vc), vecs[n].vc);
            if (ALIGN) step();
            chk($sformatf("vec%0d.de", n), int'(d1_de), int'(vecs[n].de));
            chk($sformatf("vec%0d.hsync", n), int'(d1_hs), int'(vecs[n].hs));
            chk($sformatf("vec%0d.vsync", n), int'(d1_vs), int'(vecs[n].vs));
            chk($sformatf("vec%0d.line_start", n), int'(d1_ls), int'(vecs[n].ls));
            chk($sformatf("vec%0d.frame_start", n), int'(d1_fs), int'(vecs[n].fs));
        end

        // PIX_DIV=3: tick every third clk, one step per tick, 360-clk frame.
        go_idle();
        run = 1'b1;
        for (int s = 1; s <= 364; s++) begin
            step();
            if (s <= 9) chk($sformatf("div3.h_c_en@%0d", s), int'(d3_en), (s % 3 == 0) ? 1 : 0);
            if (s == 6) chk("div3.h_c@6", int'(d3_hc), 1);
            if (s == 362) chk("div3.frame_start@362", int'(d3_fs), 0);
            if (s == 364) chk("div3.frame_start@364", int'(d3_fs), 1);
        end

        // run dropped mid-frame at (5,2), raised 4 clks later.
        go_idle();
        run = 1'b1;
        for (int s = 0; s < 36; s++) step();
        chk("drop.h_c", int'(d1_hc), 5);
        chk("drop.v_c", int'(d1_vc), 2);
        run = 1'b0;
        step();
        chk("drop.idle.h_c", int'(d1_hc), 0);
        chk("drop.idle.v_c", int'(d1_vc), 0);
        chk("drop.idle.h_c_en", int'(d1_en), 0);
        step();
        chk("drop.idle.de", int'(d1_de), 0);
        step();
        step();
        run = 1'b1;
        step();
        chk("restart.h_c", int'(d1_hc), 0);
        chk("restart.v_c", int'(d1_vc), 0);
        chk("restart.h_c_en", int'(d1_en), 1);
        if (ALIGN) step();
        chk("restart.frame_start", int'(d1_fs), 1);
        chk("restart.line_start", int'(d1_ls), 1);
        chk("restart.de", int'(d1_de), 1);

        // Random run activity with occasional asynchronous resets, against the model.
        for (int s = 0; s < 3000; s++) begin
            int thr;
            thr = (s < 1800) ? 998 : 900;
            run = ($urandom_range(0, 999) < thr);
            if ($urandom_range(0, 399) == 0) begin
                rstb = 1'b0;
                #1;
                model_reset();
                check_dut(0);
                check_dut(1);
                rstb = 1'b1;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
